// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data memory responder.
// Size codes follow RV32 load/store funct3.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    LANE_BYTE = 2'd0,
    LANE_HALF = 2'd1,
    LANE_WORD = 2'd2
  } lane_e;

  localparam logic [2:0] SIZE_B  = 3'd0;
  localparam logic [2:0] SIZE_H  = 3'd1;
  localparam logic [2:0] SIZE_W  = 3'd2;
  localparam logic [2:0] SIZE_BU = 3'd4;
  localparam logic [2:0] SIZE_HU = 3'd5;

  // Unsupported codes (3/6/7) fall through to a word access.
  function automatic lane_e size_class(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_BU: size_class = LANE_BYTE;
      SIZE_H, SIZE_HU: size_class = LANE_HALF;
      default:         size_class = LANE_WORD;
    endcase
  endfunction

  function automatic logic size_illegal(input logic [2:0] size);
    size_illegal = (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
  endfunction

  function automatic logic misaligned(input lane_e lane, input logic [1:0] off);
    case (lane)
      LANE_HALF: misaligned = off[0];
      LANE_WORD: misaligned = (off != 2'd0);
      default:   misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_offset(input lane_e lane, input logic [1:0] off);
    case (lane)
      LANE_BYTE: align_offset = off;
      LANE_HALF: align_offset = {off[1], 1'b0};
      default:   align_offset = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input lane_e lane, input logic [1:0] off);
    case (lane)
      LANE_BYTE: byte_enable = 4'b0001 << off;
      LANE_HALF: byte_enable = off[1] ? 4'b1100 : 4'b0011;
      default:   byte_enable = 4'b1111;
    endcase
  endfunction

  // Replicating the low lane lets the byte enables pick the right copy.
  function automatic logic [31:0] store_lanes(input lane_e lane, input logic [31:0] wdata);
    case (lane)
      LANE_BYTE: store_lanes = {4{wdata[7:0]}};
      LANE_HALF: store_lanes = {2{wdata[15:0]}};
      default:   store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] lane_select(input lane_e lane, input logic [1:0] off,
                                              input logic [31:0] word);
    case (lane)
      LANE_BYTE: lane_select = {24'h0, word[{off, 3'b000} +: 8]};
      LANE_HALF: lane_select = {16'h0, word[{off[1], 4'b0000} +: 16]};
      default:   lane_select = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 storage with registered read and byte-enable write.
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding data memory responder, fixed 3-cycle request cycle.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned/unsupported accesses with rsp_err.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a handshake
// ACCESS | one array read or byte-enabled write
// RESP   | one-cycle rsp_valid pulse with data/error
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e state_q, state_d;

  logic              write_q;
  lane_e             lane_q;
  logic [1:0]        off_q;
  logic [RAM_AW-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  lane_e             req_lane;
  logic [1:0]        req_off;
  logic [RAM_AW-1:0] req_idx;
  logic              req_err;

  logic              ram_rd;
  logic              ram_wr;
  logic [31:0]       ram_rdata;

  assign req_lane = size_class(req_size);
  assign req_off  = align_offset(req_lane, req_addr[1:0]);
  // Word indices beyond the array wrap rather than alias out of range.
  assign req_idx  = RAM_AW'(32'(req_addr[ADDR_W-1:2]) % DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_err = size_illegal(req_size) || misaligned(req_lane, req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      lane_q  <= LANE_WORD;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        write_q <= req_write;
        lane_q  <= req_lane;
        off_q   <= req_off;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_rd  = !write_q && !err_q;
        ram_wr  = write_q && !err_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!write_q && !err_q) rsp_rdata = lane_select(lane_q, off_q, ram_rdata);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rd_en (ram_rd),
    .wr_en (ram_wr),
    .be    (byte_enable(lane_q, off_q)),
    .idx   (idx_q),
    .wdata (store_lanes(lane_q, wdata_q)),
    .rdata (ram_rdata)
  );

endmodule
